// File: rtl/regfile_mp_if.sv
// regfile_mp_if: bus bundle between the core pipeline and the register file.
//   master : decode/writeback side, which drives the write port, the read
//            addresses and the clear request, and observes the read data and
//            the clear status.
//   slave  : the register file itself.
//   Signals:
//     we, waddr, wdata : write port.
//     raddr            : packed read addresses, port i is [i*AW +: AW].
//     rdata            : packed read data, port i is [i*XLEN +: XLEN].
//     clr_req          : one-cycle request that starts a sequenced clear.
//     clr_busy         : high while the clear engine is running.
//     clr_done         : one-cycle pulse on the cycle the last entry is cleared.
interface regfile_mp_if #(
  parameter int XLEN   = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                     we;
  logic [AW-1:0]            waddr;
  logic [XLEN-1:0]          wdata;
  logic [NUM_RD*AW-1:0]     raddr;
  logic [NUM_RD*XLEN-1:0]   rdata;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     clr_done;

  modport master (
    output we, waddr, wdata, raddr, clr_req,
    input  rdata, clr_busy, clr_done
  );

  modport slave (
    input  we, waddr, wdata, raddr, clr_req,
    output rdata, clr_busy, clr_done
  );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file for the RV32 core.
//   - NUM_RD independent read ports with write-first bypass from the write port
//   - optional hardwired-zero register 0 (ZERO_R0)
//   - optional registered read data with one cycle of latency (READ_REG)
//   - clear engine that zeroes one entry per cycle after a clr_req pulse
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset; zeroes storage, read registers, FSM
//   bus : regfile_mp_if.slave (write port, read ports, clear handshake)

// One read lane: select between zero, bypassed write data and stored data,
// then optionally register the result.
module regfile_mp_rport #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int READ_REG = 0,
  parameter int ZERO_R0  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [DEPTH-1:0][XLEN-1:0]  mem,
  input  logic [AW-1:0]               raddr,
  input  logic                        wr_ok,
  input  logic [AW-1:0]               waddr,
  input  logic [XLEN-1:0]             wdata,
  output logic [XLEN-1:0]             rdata
);
  logic [XLEN-1:0] rd_d;
  logic [XLEN-1:0] rd_q;

  always_comb begin
    if (ZERO_R0 != 0 && raddr == '0)
      rd_d = '0;
    else if (wr_ok && waddr == raddr)
      rd_d = wdata;
    else
      rd_d = mem[raddr];
  end

  // The capture register is always present; READ_REG only chooses which
  // side feeds the output, so both configurations share one netlist shape.
  always_ff @(posedge clk) begin
    if (rst) rd_q <= '0;
    else     rd_q <= rd_d;
  end

  assign rdata = (READ_REG != 0) ? rd_q : rd_d;
endmodule

module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 32,
  parameter int NUM_RD   = 2,
  parameter int READ_REG = 0,
  parameter int ZERO_R0  = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);
  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                      state, state_nxt;
  logic [AW-1:0]               ptr;
  logic [DEPTH-1:0][XLEN-1:0]  mem;
  logic                        wr_ok;
  logic [NUM_RD-1:0][AW-1:0]   ra_lane;
  logic [NUM_RD-1:0][XLEN-1:0] rd_lane;

  // Writes to register 0 are dropped when it is hardwired, and the dropped
  // write must not feed the bypass either.
  assign wr_ok = bus.we && !(ZERO_R0 != 0 && bus.waddr == '0);

  // ---------------- clear engine FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      // DEPTH is a power of two, so ptr wraps back to 0 after LAST.
      ptr   <= (state == CLEAR) ? ptr + 1'b1 : '0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.clr_req)  state_nxt = CLEAR;
      CLEAR:   if (ptr == LAST)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.clr_busy = (state == CLEAR);
    bus.clr_done = (state == CLEAR) && (ptr == LAST);
  end

  // ---------------- storage ----------------
  // The clear assignment comes last so it wins over a same-address write.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem <= '0;
    end else begin
      if (wr_ok)           mem[bus.waddr] <= bus.wdata;
      if (state == CLEAR)  mem[ptr]       <= '0;
    end
  end

  // ---------------- read lanes ----------------
  assign ra_lane   = bus.raddr;
  assign bus.rdata = rd_lane;

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    regfile_mp_rport #(
      .XLEN(XLEN), .DEPTH(DEPTH), .AW(AW),
      .READ_REG(READ_REG), .ZERO_R0(ZERO_R0)
    ) u_rport (
      .clk   (clk),
      .rst   (rst),
      .mem   (mem),
      .raddr (ra_lane[i]),
      .wr_ok (wr_ok),
      .waddr (bus.waddr),
      .wdata (bus.wdata),
      .rdata (rd_lane[i])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp. Two instances share the same
// stimulus: dut0 uses combinational reads, dut1 registered reads.
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int DEPTH = 32;
  localparam int NUM_RD = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  regfile_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) rfi0 ();
  regfile_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD)) rfi1 ();

  assign rfi1.we      = rfi0.we;
  assign rfi1.waddr   = rfi0.waddr;
  assign rfi1.wdata   = rfi0.wdata;
  assign rfi1.raddr   = rfi0.raddr;
  assign rfi1.clr_req = rfi0.clr_req;

  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .READ_REG(0), .ZERO_R0(1))
    dut0 (.clk(clk), .rst(rst), .bus(rfi0));
  regfile_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .READ_REG(1), .ZERO_R0(1))
    dut1 (.clk(clk), .rst(rst), .bus(rfi1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ra(input logic [4:0] a0, input logic [4:0] a1);
    rfi0.raddr = {a1, a0};
  endtask

  // Read every address on both ports of dut0 and expect zero.
  task automatic sweep_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      set_ra(5'(a), 5'(DEPTH - 1 - a));
      #1;
      chk({tag, "_p0"}, rfi0.rdata[0 +: XLEN], 32'h0);
      chk({tag, "_p1"}, rfi0.rdata[XLEN +: XLEN], 32'h0);
      tick();
    end
  endtask

  // Pulse clr_req and watch the engine for 40 cycles. Optionally write x31
  // during the 3rd busy cycle, and optionally assert rst in busy cycle rst_at.
  task automatic run_clear(input bit do_wr, input int rst_at,
                           output int nb, output int nd, output int dat);
    nb = 0; nd = 0; dat = 0;
    rfi0.clr_req = 1'b1;
    tick();
    rfi0.clr_req = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      rfi0.we      = 1'b0;
      rfi0.clr_req = (c == 5);   // ignored while clearing
      rst          = (c == rst_at);
      if (do_wr && c == 3) begin
        rfi0.we = 1'b1; rfi0.waddr = 5'd31; rfi0.wdata = 32'hAA;
        set_ra(5'd2, 5'd31);
      end
      if (do_wr && c == 10) set_ra(5'd31, 5'd0);
      #1;
      if (rfi0.clr_busy) nb++;
      if (rfi0.clr_done) begin nd++; dat = c; end
      if (do_wr && c == 3) begin
        chk("clr_ptr_preclear", rfi0.rdata[0 +: XLEN], 32'd2);
        chk("clr_wr_bypass", rfi0.rdata[XLEN +: XLEN], 32'hAA);
      end
      if (do_wr && c == 10) chk("clr_x31_written", rfi0.rdata[0 +: XLEN], 32'hAA);
      tick();
    end
    rst = 1'b0;
    rfi0.clr_req = 1'b0;
    rfi0.we = 1'b0;
  endtask

  initial begin
    int nb, nd, dat;
    rfi0.we = 1'b0; rfi0.waddr = '0; rfi0.wdata = '0;
    rfi0.raddr = '0; rfi0.clr_req = 1'b0;

    // Reset
    tick(); tick();
    chk("rst_busy", 32'(rfi0.clr_busy), 32'd0);
    chk("rst_done", 32'(rfi0.clr_done), 32'd0);
    chk("rst_rreg_p0", rfi1.rdata[0 +: XLEN], 32'h0);
    rst = 1'b0;
    sweep_zero("rst_read");

    // Write x5, read next cycle
    rfi0.we = 1'b1; rfi0.waddr = 5'd5; rfi0.wdata = 32'hDEADBEEF;
    tick();
    rfi0.we = 1'b0;
    set_ra(5'd5, 5'd0);
    #1;
    chk("x5_p0", rfi0.rdata[0 +: XLEN], 32'hDEADBEEF);
    chk("x0_p1", rfi0.rdata[XLEN +: XLEN], 32'h0);
    tick();

    // Same-cycle bypass of x7; dut1 shows it one cycle later
    rfi0.we = 1'b1; rfi0.waddr = 5'd7; rfi0.wdata = 32'h12345678;
    set_ra(5'd7, 5'd5);
    #1;
    chk("byp_x7_comb", rfi0.rdata[0 +: XLEN], 32'h12345678);
    chk("rreg_prev_x5", rfi1.rdata[0 +: XLEN], 32'hDEADBEEF);
    tick();
    rfi0.we = 1'b0;
    #1;
    chk("byp_x7_reg", rfi1.rdata[0 +: XLEN], 32'h12345678);
    chk("rreg_p1_x5", rfi1.rdata[XLEN +: XLEN], 32'hDEADBEEF);
    tick();

    // Bypass on port 1
    rfi0.we = 1'b1; rfi0.waddr = 5'd9; rfi0.wdata = 32'h55;
    set_ra(5'd7, 5'd9);
    #1;
    chk("byp_x9_p1", rfi0.rdata[XLEN +: XLEN], 32'h55);
    chk("x7_p0", rfi0.rdata[0 +: XLEN], 32'h12345678);
    tick();

    // Write to x0 is dropped, bypass suppressed
    rfi0.we = 1'b1; rfi0.waddr = 5'd0; rfi0.wdata = 32'hFFFFFFFF;
    set_ra(5'd0, 5'd0);
    #1;
    chk("x0_byp_p0", rfi0.rdata[0 +: XLEN], 32'h0);
    chk("x0_byp_p1", rfi0.rdata[XLEN +: XLEN], 32'h0);
    tick();
    rfi0.we = 1'b0;
    #1;
    chk("x0_later", rfi0.rdata[0 +: XLEN], 32'h0);
    chk("x0_rreg", rfi1.rdata[0 +: XLEN], 32'h0);
    tick();

    // Fill x1..x31 with their index
    for (int i = 1; i < DEPTH; i++) begin
      rfi0.we = 1'b1; rfi0.waddr = 5'(i); rfi0.wdata = 32'(i);
      tick();
    end
    rfi0.we = 1'b0;
    set_ra(5'd31, 5'd1);
    #1;
    chk("fill_x31", rfi0.rdata[0 +: XLEN], 32'd31);
    chk("fill_x1", rfi0.rdata[XLEN +: XLEN], 32'd1);
    tick();

    // Full clear with a write to x31 in the 3rd busy cycle
    run_clear(1'b1, 0, nb, nd, dat);
    chk("clr_busy_cycles", 32'(nb), 32'd32);
    chk("clr_done_count", 32'(nd), 32'd1);
    chk("clr_done_cycle", 32'(dat), 32'd32);
    sweep_zero("after_clr");

    // Refill a few entries, then reset mid-clear at ptr=10
    rfi0.we = 1'b1; rfi0.waddr = 5'd20; rfi0.wdata = 32'h77;
    tick();
    rfi0.waddr = 5'd3; rfi0.wdata = 32'h33;
    tick();
    rfi0.we = 1'b0;
    set_ra(5'd20, 5'd3);
    #1;
    chk("refill_x20", rfi0.rdata[0 +: XLEN], 32'h77);
    tick();
    run_clear(1'b0, 11, nb, nd, dat);
    chk("rst_mid_busy_cycles", 32'(nb), 32'd11);
    chk("rst_mid_no_done", 32'(nd), 32'd0);
    chk("rst_mid_busy_now", 32'(rfi0.clr_busy), 32'd0);
    sweep_zero("after_rst_mid");

    // A fresh request runs the whole sequence
    run_clear(1'b0, 0, nb, nd, dat);
    chk("reclr_busy_cycles", 32'(nb), 32'd32);
    chk("reclr_done_count", 32'(nd), 32'd1);
    chk("reclr_done_cycle", 32'(dat), 32'd32);

    // clr_req together with rst: reset wins
    rst = 1'b1; rfi0.clr_req = 1'b1;
    tick();
    rst = 1'b0; rfi0.clr_req = 1'b0;
    #1;
    chk("req_rst_busy0", 32'(rfi0.clr_busy), 32'd0);
    tick();
    chk("req_rst_busy1", 32'(rfi0.clr_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the RV32 core. It generalises the 32:1 register-select mux into a complete storage block with:
- N read ports;
- one write port with write-to-read bypass;
- x0 hardwired to zero;
- optional registered read outputs;
- a sequenced clear engine that zeroes the array one entry per cycle.

It sits between decode (read addresses) and writeback (write port).

## Interface
- `XLEN`, 32: data width per register.
- `DEPTH`, 32: number of registers. Power of two, ≥ 2. `AW = $clog2(DEPTH)`.
- `NUM_RD`, 2: number of read ports, 1–4.
- `READ_REG`, 0: 0 = combinational read; 1 = registered read with 1-cycle latency.
- `ZERO_R0`, 1: 1 = register 0 always reads 0 and writes to it are dropped.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `we` in 1: write enable.
- `waddr` in AW: write address.
- `wdata` in XLEN: write data.
- `raddr` in NUM_RD*AW: packed read addresses; port i is `[i*AW +: AW]`.
- `rdata` out NUM_RD*XLEN: packed read data; port i is `[i*XLEN +: XLEN]`.
- `clr_req` in 1: one-cycle pulse that starts a sequenced clear of the whole array.
- `clr_busy` out 1: high while the clear engine is running.
- `clr_done` out 1: one-cycle pulse on the cycle the last entry is cleared.

## Operation
- Storage: array of DEPTH × XLEN flops. `rst` zeroes every entry in the same cycle.
- Write: on a rising edge with `we=1`, `mem[waddr] <= wdata`. If `ZERO_R0=1` and `waddr=0`, the write is ignored.
- Read, per port i (independent, identical logic), in priority order:
  - `ZERO_R0=1` and `raddr_i=0` → 0.
  - Otherwise `we=1`, `waddr==raddr_i` and the write is not dropped → `wdata` (bypass, write-first).
  - Otherwise → `mem[raddr_i]`.
- `READ_REG=0`: `rdata` is combinational from the current `raddr`, `we`, `waddr` and `wdata`.
- `READ_REG=1`: the value above is captured at the edge and presented on the next cycle.
- Clear engine FSM:
  - IDLE: `clr_busy=0`. On `clr_req=1` → CLEAR with pointer `ptr=0`.
  - CLEAR: each cycle `mem[ptr] <= 0` and `ptr++`.
    - When `ptr==DEPTH-1`: clear the entry, pulse `clr_done`, → IDLE.
    - `clr_busy=1` throughout CLEAR.
  - `clr_req` while in CLEAR is ignored; no restart.
- Write during CLEAR:
  - Same address as `ptr`: the clear wins and the entry becomes 0.
  - Different address: the write proceeds normally.
  - Bypass is computed from the external write only; a same-cycle read of `ptr` returns `mem[ptr]` (pre-clear value), or `wdata` if `waddr==ptr`.
- `rst` mid-clear: FSM → IDLE, `ptr=0`, all entries 0, `clr_busy=0`, no `clr_done` pulse.

## Timing
- Reset values: all `mem`=0, `rdata`=0 (registered form; combinational form follows `mem`, so reads 0), `clr_busy`=0, `clr_done`=0, FSM=IDLE.
- Write latency: 1 edge. A read on the same cycle sees the new data through the bypass.
- Read latency: 0 cycles for `READ_REG=0`, 1 cycle for `READ_REG=1`.
- Clear:
  - `clr_req` sampled at edge T → `clr_busy=1` from T+1.
  - Entry k cleared at edge T+1+k.
  - `clr_done` high during cycle T+DEPTH; `clr_busy` falls at T+DEPTH+1.
  - Total DEPTH busy cycles.
- `clr_req` on the same cycle as `rst`: reset wins and the FSM stays IDLE.

## Test plan
- Reset, then read all 32 addresses on both ports → every read returns 0x00000000; `clr_busy`=0.
- Write 0xDEADBEEF to x5, then next cycle read x5 on port 0 and x0 on port 1 → port 0 returns 0xDEADBEEF, port 1 returns 0.
- Write x7=0x12345678 with `raddr0=7` on the same cycle, `READ_REG=0` → `rdata0`=0x12345678 in that cycle. With `READ_REG=1` → same value one cycle later.
- Write x0=0xFFFFFFFF, then read x0 on a later cycle → returns 0; the same-cycle read also returns 0 (bypass suppressed).
- Fill x1..x31 with value `i`, pulse `clr_req`, and write x31=0xAA at the 3rd busy cycle:
  - `clr_busy` stays high exactly 32 cycles and `clr_done` pulses once;
  - afterwards all entries read 0, including x31, because it was cleared at ptr=31 after the write.
- Start a clear, assert `rst` at ptr=10 → next cycle `clr_busy`=0, all entries 0, no `clr_done`. A subsequent `clr_req` runs the full 32-cycle sequence.
